// File: rtl/lbdr_input_fifo_pkg.sv
// Shared LBDR parameters: flit type codes, flit field layout and the
// write-side framing FSM state encoding.
package lbdr_input_fifo_pkg;

   // Flit type codes carried in the top three bits of every flit
   localparam logic [2:0] FLIT_HEADER  = 3'b001;
   localparam logic [2:0] FLIT_PAYLOAD = 3'b010;
   localparam logic [2:0] FLIT_TAIL    = 3'b100;

   // Field widths and MSB offsets measured down from the flit MSB
   localparam int FLIT_TYPE_W  = 3;
   localparam int DST_ADDR_W   = 4;
   localparam int FLIT_TYPE_OFS = 1;   // type field MSB is DATA_WIDTH-1
   localparam int DST_ADDR_OFS  = 4;   // dst field MSB is DATA_WIDTH-4

   // Write-side packet framing states
   typedef enum logic {
      IDLE   = 1'b0,
      IN_PKT = 1'b1
   } frame_state_t;

endpackage

// File: rtl/lbdr_input_fifo_framing_check.sv
// Write-side packet framing tracker plus sticky error flag for the LBDR
// input FIFO. Only instantiated when LBDR_FIFO_CHECK_EN is defined.
module lbdr_fifo_framing_check
   import lbdr_input_fifo_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_accept,
   input  logic [2:0] wr_type,
   input  logic       overflow,
   input  logic       underflow,
   output logic       err
);

   frame_state_t state_r;
   frame_state_t state_next_s;
   logic         violation_s;
   logic         err_r;
   logic         err_next_s;

   // Next framing state and violation detect; only accepted writes advance
   always_comb begin
      state_next_s = state_r;
      violation_s  = 1'b0;
      if (wr_accept) begin
         case (state_r)
            IDLE: begin
               case (wr_type)
                  FLIT_HEADER:  state_next_s = IN_PKT;
                  FLIT_PAYLOAD: violation_s  = 1'b1;
                  FLIT_TAIL:    violation_s  = 1'b1;
                  default:      violation_s  = 1'b1;
               endcase
            end
            IN_PKT: begin
               case (wr_type)
                  FLIT_HEADER:  violation_s  = 1'b1;
                  FLIT_PAYLOAD: state_next_s = IN_PKT;
                  FLIT_TAIL:    state_next_s = IDLE;
                  default:      violation_s  = 1'b1;
               endcase
            end
            default: begin
               state_next_s = IDLE;
               violation_s  = 1'b1;
            end
         endcase
      end else begin
         state_next_s = state_r;
         violation_s  = 1'b0;
      end
   end

   // Error accumulates any overflow, underflow or framing violation
   always_comb begin
      err_next_s = err_r | violation_s | overflow | underflow;
   end

   // Framing state and sticky error registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_next_s;
         err_r   <= err_next_s;
      end
   end

   assign err = err_r;

endmodule

// File: rtl/lbdr_input_fifo.sv
// Per-port first-word-fall-through input FIFO feeding LBDR. Presents the
// head flit type/destination, returns one credit per dequeued flit.
// Optional checking (overflow, underflow, framing) under LBDR_FIFO_CHECK_EN;
// without it err is constant 0.
module lbdr_input_fifo
   import lbdr_input_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  read_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [2:0]            flit_id,
   output logic [3:0]            dst_addr,
   output logic                  empty,
   output logic                  full,
   output logic                  credit_out,
   output logic                  err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_r;
   logic [PTR_W-1:0]      rd_ptr_r;
   logic [CNT_W-1:0]      count_r;
   logic [CNT_W-1:0]      count_next_s;
   logic                  empty_r;
   logic                  full_r;
   logic                  credit_r;
   logic                  wr_accept_s;
   logic                  rd_accept_s;

   // Full/empty come from registered state, so a write while full is dropped
   assign wr_accept_s = valid_in & ~full_r;
   assign rd_accept_s = read_en  & ~empty_r;

   // Occupancy update; simultaneous write and read leaves it unchanged
   always_comb begin
      count_next_s = count_r;
      case ({wr_accept_s, rd_accept_s})
         2'b10:   count_next_s = count_r + CNT_W'(1);
         2'b01:   count_next_s = count_r - CNT_W'(1);
         default: count_next_s = count_r;
      endcase
   end

   // Pointers, occupancy, status flags and credit pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         empty_r  <= 1'b1;
         full_r   <= 1'b0;
         credit_r <= 1'b0;
      end else begin
         if (wr_accept_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (rd_accept_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         count_r  <= count_next_s;
         empty_r  <= (count_next_s == CNT_W'(0));
         full_r   <= (count_next_s == CNT_W'(DEPTH));
         credit_r <= rd_accept_s;
      end
   end

   // Flit storage; contents are deliberately left unreset
   always_ff @(posedge clk) begin
      if (wr_accept_s) begin
         mem[wr_ptr_r] <= data_in;
      end
   end

   assign data_out   = mem[rd_ptr_r];
   assign flit_id    = data_out[DATA_WIDTH-FLIT_TYPE_OFS -: FLIT_TYPE_W];
   assign dst_addr   = data_out[DATA_WIDTH-DST_ADDR_OFS -: DST_ADDR_W];
   assign empty      = empty_r;
   assign full       = full_r;
   assign credit_out = credit_r;

`ifdef LBDR_FIFO_CHECK_EN
   lbdr_fifo_framing_check u_framing_check (
      .clk       (clk),
      .rst       (rst),
      .wr_accept (wr_accept_s),
      .wr_type   (data_in[DATA_WIDTH-FLIT_TYPE_OFS -: FLIT_TYPE_W]),
      .overflow  (valid_in & full_r),
      .underflow (read_en & empty_r),
      .err       (err)
   );
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lbdr_input_fifo.sv
// Directed self-checking bench for lbdr_input_fifo (DEPTH 4, 32-bit flits).
module tb_lbdr_input_fifo;
   import lbdr_input_fifo_pkg::*;

`ifdef LBDR_FIFO_CHECK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        valid_in;
   logic [31:0] data_in;
   logic        read_en;
   logic [31:0] data_out;
   logic [2:0]  flit_id;
   logic [3:0]  dst_addr;
   logic        empty;
   logic        full;
   logic        credit_out;
   logic        err;

   int n_checks = 0;
   int n_fail   = 0;

   lbdr_input_fifo #(.DATA_WIDTH(32), .DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .valid_in   (valid_in),
      .data_in    (data_in),
      .read_en    (read_en),
      .data_out   (data_out),
      .flit_id    (flit_id),
      .dst_addr   (dst_addr),
      .empty      (empty),
      .full       (full),
      .credit_out (credit_out),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [2:0] t, input logic [3:0] d, input logic [24:0] tag);
      return {t, d, tag};
   endfunction

   // Drive one cycle of inputs, step past the rising edge, sample at +1
   task automatic cyc(input logic v, input logic [31:0] d, input logic r);
      valid_in = v;
      data_in  = d;
      read_en  = r;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      valid_in = 1'b0;
      read_en  = 1'b0;
      data_in  = 32'h0;
      rst      = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] fl [4];
      logic [31:0] prev;
      logic [31:0] p;

      rst      = 1'b1;
      valid_in = 1'b0;
      read_en  = 1'b0;
      data_in  = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      check("rst_empty",  32'(empty),      32'd1);
      check("rst_full",   32'(full),       32'd0);
      check("rst_err",    32'(err),        32'd0);
      check("rst_credit", 32'(credit_out), 32'd0);

      // First header becomes visible right after its write edge
      fl[0] = mk(FLIT_HEADER,  4'hA, 25'd1);
      fl[1] = mk(FLIT_PAYLOAD, 4'hA, 25'd2);
      fl[2] = mk(FLIT_PAYLOAD, 4'hA, 25'd3);
      fl[3] = mk(FLIT_TAIL,    4'hA, 25'd4);
      cyc(1'b1, fl[0], 1'b0);
      check("hdr_empty",   32'(empty),    32'd0);
      check("hdr_flit_id", 32'(flit_id),  32'(3'b001));
      check("hdr_dst",     32'(dst_addr), 32'(4'hA));
      check("hdr_data",    data_out,      fl[0]);

      // Fill to full, then an overflow write is dropped
      cyc(1'b1, fl[1], 1'b0);
      cyc(1'b1, fl[2], 1'b0);
      check("fill3_full", 32'(full), 32'd0);
      cyc(1'b1, fl[3], 1'b0);
      check("fill4_full", 32'(full), 32'd1);
      check("fill4_err",  32'(err),  32'd0);
      cyc(1'b1, mk(FLIT_HEADER, 4'h5, 25'd5), 1'b0);
      check("ovf_full", 32'(full), 32'd1);
      check("ovf_err",  32'(err),  32'(EXP_ERR));
      check("ovf_head", data_out,  fl[0]);

      // Drain in order with one credit per read
      for (int i = 0; i < 4; i++) begin
         check("drain_data", data_out, fl[i]);
         cyc(1'b0, 32'h0, 1'b1);
         check("drain_credit", 32'(credit_out), 32'd1);
      end
      check("drain_empty", 32'(empty), 32'd1);
      check("drain_full",  32'(full),  32'd0);
      cyc(1'b0, 32'h0, 1'b0);
      check("drain_credit_end", 32'(credit_out), 32'd0);

      // One flit held, 10 cycles of simultaneous write and read
      do_reset();
      prev = mk(FLIT_HEADER, 4'h3, 25'd16);
      cyc(1'b1, prev, 1'b0);
      for (int i = 0; i < 10; i++) begin
         p = mk(FLIT_PAYLOAD, 4'h3, 25'(32 + i));
         check("rw_data", data_out, prev);
         cyc(1'b1, p, 1'b1);
         check("rw_credit", 32'(credit_out), 32'd1);
         check("rw_empty",  32'(empty),      32'd0);
         check("rw_full",   32'(full),       32'd0);
         prev = p;
      end
      check("rw_last",  data_out,  prev);
      check("rw_err",   32'(err),  32'd0);
      cyc(1'b0, 32'h0, 1'b1);
      check("rw_final_credit", 32'(credit_out), 32'd1);
      check("rw_final_empty",  32'(empty),      32'd1);

      // Legal packet then a new header: no error; header mid-packet flags
      do_reset();
      cyc(1'b1, mk(FLIT_HEADER,  4'h7, 25'd64), 1'b0);
      cyc(1'b1, mk(FLIT_PAYLOAD, 4'h7, 25'd65), 1'b0);
      cyc(1'b1, mk(FLIT_TAIL,    4'h7, 25'd66), 1'b0);
      cyc(1'b1, mk(FLIT_HEADER,  4'h7, 25'd67), 1'b0);
      check("frame_ok_err",  32'(err),  32'd0);
      check("frame_ok_full", 32'(full), 32'd1);
      cyc(1'b0, 32'h0, 1'b1);
      check("frame_rd_credit", 32'(credit_out), 32'd1);
      cyc(1'b1, mk(FLIT_HEADER, 4'h7, 25'd68), 1'b0);
      check("frame_hdr_in_pkt_err", 32'(err),  32'(EXP_ERR));
      check("frame_hdr_in_pkt_full", 32'(full), 32'd1);

      // Payload while idle flags but is still stored
      do_reset();
      p = mk(FLIT_PAYLOAD, 4'h2, 25'd80);
      cyc(1'b1, p, 1'b0);
      check("idle_pay_err",   32'(err),     32'(EXP_ERR));
      check("idle_pay_empty", 32'(empty),   32'd0);
      check("idle_pay_id",    32'(flit_id), 32'(3'b010));
      check("idle_pay_data",  data_out,     p);

      // Read while empty: no credit, pointers stay put
      do_reset();
      cyc(1'b0, 32'h0, 1'b1);
      check("udf_credit", 32'(credit_out), 32'd0);
      check("udf_empty",  32'(empty),      32'd1);
      check("udf_err",    32'(err),        32'(EXP_ERR));
      p = mk(FLIT_HEADER, 4'hC, 25'd96);
      cyc(1'b1, p, 1'b0);
      check("udf_then_data",  data_out,   p);
      check("udf_then_empty", 32'(empty), 32'd0);

      // Asynchronous reset mid-cycle with 3 flits stored
      do_reset();
      cyc(1'b1, mk(FLIT_PAYLOAD, 4'h1, 25'd112), 1'b0);
      cyc(1'b1, mk(FLIT_HEADER,  4'h1, 25'd113), 1'b0);
      cyc(1'b1, mk(FLIT_PAYLOAD, 4'h1, 25'd114), 1'b0);
      check("pre_arst_err",   32'(err),   32'(EXP_ERR));
      check("pre_arst_empty", 32'(empty), 32'd0);
      valid_in = 1'b0;
      read_en  = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      check("arst_empty",  32'(empty),      32'd1);
      check("arst_full",   32'(full),       32'd0);
      check("arst_err",    32'(err),        32'd0);
      check("arst_credit", 32'(credit_out), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc(1'b0, 32'h0, 1'b1);
      check("post_arst_credit1", 32'(credit_out), 32'd0);
      check("post_arst_empty",   32'(empty),      32'd1);
      cyc(1'b0, 32'h0, 1'b1);
      check("post_arst_credit2", 32'(credit_out), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lbdr_input_fifo.md
# lbdr_input_fifo

Per-port input buffer that sits directly upstream of the LBDR routing stage in each router input channel. Stores incoming flits in a first-word-fall-through FIFO and presents the head flit's `flit_id`, `dst_addr` and `empty` status to LBDR. Returns one credit per flit dequeued, so the upstream router's output port can track free buffer slots. Also tracks packet framing on the write side.

## Interface
- `DATA_WIDTH`, 32: flit width in bits; minimum 8.
- `DEPTH`, 4: number of flit slots; power of two, at least 2.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `valid_in`  in  1: upstream presents a flit on `data_in` this cycle.
- `data_in`  in  DATA_WIDTH: incoming flit. Field `[DATA_WIDTH-1 -: 3]` is the flit type. Field `[DATA_WIDTH-4 -: 4]` is the destination address (header flits only).
- `read_en`  in  1: downstream (allocator/crossbar) dequeues the head flit.
- `data_out`  out  DATA_WIDTH: head flit, fall-through.
- `flit_id`  out  3: type field of the head flit; drives the LBDR input of the same name.
- `dst_addr`  out  4: destination field of the head flit; drives the LBDR input of the same name.
- `empty`  out  1: FIFO holds no flits; drives LBDR `empty`.
- `full`  out  1: FIFO holds DEPTH flits.
- `credit_out`  out  1: one-cycle pulse per dequeued flit, returned upstream.
- `err`  out  1: sticky protocol/overflow error (see Configuration).

## Operation
- Storage: DEPTH-entry register array; binary read/write pointers of width log2(DEPTH); occupancy counter of width log2(DEPTH)+1.
- Write: when `valid_in && !full`, the flit goes into `mem[wr_ptr]` and `wr_ptr` increments, wrapping at DEPTH. When `valid_in && full`, the flit is dropped and state is unchanged. A write accepted in the same cycle as a read while full is not allowed; `full` is the registered value.
- Read: when `read_en && !empty`, `rd_ptr` increments, wrapping at DEPTH. When `read_en && empty`, nothing happens and no credit is issued.
- Occupancy:
  - +1 on write only.
  - −1 on read only.
  - Unchanged on a simultaneous accepted write and read.
  - `empty` = (count == 0); `full` = (count == DEPTH).
- Outputs: `data_out`, `flit_id` and `dst_addr` come combinationally from `mem[rd_ptr]`. Their value is don't-care while `empty`; LBDR ignores them because `empty` forces its ports low.
- Write-side framing FSM has two states, IDLE and IN_PKT. It advances only on accepted writes:
  - IDLE + HEADER → IN_PKT.
  - IN_PKT + PAYLOAD → IN_PKT.
  - IN_PKT + TAIL → IDLE.
  - IDLE + PAYLOAD or TAIL → protocol violation; stay in IDLE.
  - IN_PKT + HEADER → protocol violation; stay in IN_PKT.
  - Any unknown type code → protocol violation; no state change.

## Timing
- Reset values:
  - Pointers, count and `credit_out` = 0.
  - `empty` = 1, `full` = 0, `err` = 0.
  - FSM = IDLE.
  - Memory contents are not reset.
- Latency:
  - A flit written at edge N is visible on `data_out`/`flit_id`/`dst_addr` with `empty` = 0 after edge N.
  - LBDR samples the flit at edge N+1, so routing output is available after edge N+1.
- `credit_out` is registered: it is high for exactly one cycle following each accepted read edge. Back-to-back reads produce back-to-back pulses.
- Reset asserted mid-packet: all flits are discarded, FSM returns to IDLE, and no credits are issued for discarded flits. The upstream side is reset by the same `rst`.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble; full/empty are decided by count only.

## Configuration
- `LBDR_FIFO_CHECK_EN` defined:
  - `err` sets on a write while `full` (overflow), on a read while `empty` (underflow), or on any framing violation.
  - `err` stays set until `rst`.
- Not defined: `err` is tied to 0 and the overflow/underflow/framing checks are not synthesized. Data path, FSM-free write/read behaviour and credits are identical in both builds.

## Structure
- Flit type codes (`HEADER` = 3'b001, `PAYLOAD` = 3'b010, `TAIL` = 3'b100) and the flit field offsets belong in the shared parameters package used by LBDR.
- The framing FSM state enum also goes in that package.
- Natural sub-module: `lbdr_fifo_framing_check`, holding the FSM plus error logic, instantiated only under `LBDR_FIFO_CHECK_EN`.

## Test plan
- After reset, write HEADER with dst 4'hA → next cycle: `empty` = 0, `flit_id` = 3'b001, `dst_addr` = 4'hA.
- Write 4 flits with no reads (DEPTH = 4) → `full` = 1. A 5th write is dropped and `err` = 1 with the macro, 0 without. Then read 4 → flits come out in order, 4 `credit_out` pulses, `empty` = 1.
- Hold one flit stored, then do simultaneous write and read for 10 cycles → count stays 1, order is preserved, 10 credits issued, pointers wrap cleanly.
- Write PAYLOAD while FSM is IDLE → `err` = 1 (macro on), flit still stored. Write HEADER, PAYLOAD, TAIL → `err` unchanged, FSM ends in IDLE.
- `read_en` while empty → no credit, pointers unchanged, `err` = 1 only with the macro.
- Assert `rst` asynchronously between edges with 3 flits stored → `empty` = 1, `full` = 0, `err` = 0 immediately, and no credit pulses follow.
